bin_bcd_seq: RTL and testbench
==============================

# bin_bcd_seq

Sequential, parametrised binary-to-BCD converter for the frequency counter's display path. It runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock, on a registered shift register, instead of unrolling it combinationally. This keeps logic depth flat for wide counter values. A start/busy/done handshake lets the counter-capture logic hand over a value and the display driver latch the result, and an overflow flag reports values that do not fit in the configured digit count.

## Interface
- BIN_W, 12, width of binary input; legal range ≥ 1.
- DIGITS, 4, number of BCD output digits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to convert `binary`; sampled on the rising edge of clk.
- binary  input  BIN_W  unsigned value to convert; sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd` and `overflow` are updated.
- bcd  output  4*DIGITS  result; digit k is `bcd[4k+3:4k]`, and digit 0 is the ones digit.
- overflow  output  1  high if the last result exceeded 10^DIGITS − 1.

## Operation
- **States:**
  - IDLE: waiting for start.
  - SHIFT: running BIN_W iterations.
- **Internal registers:**
  - Shift register: 4*DIGITS + BIN_W bits, with the digit field on top and the binary field on the bottom.
  - Iteration counter: width clog2(BIN_W+1).
  - Overflow accumulator: 1 bit.
- **IDLE to SHIFT:** taken on an edge where start=1. On that edge:
  - digit field ← 0 and binary field ← `binary`;
  - counter ← 0 and overflow accumulator ← 0;
  - busy ← 1.
- **Each SHIFT edge:**
  - Every 4-bit digit whose value is ≥ 5 gets +3 added (mod 16).
  - The accumulator ORs in the corrected register's MSB.
  - The register shifts left by 1 with zero fill, and the counter increments.
- **Final SHIFT edge:** on the edge where the counter reaches BIN_W−1, the completion values are computed from the post-shift digit field and the final accumulator. On that edge:
  - `bcd` ← the post-shift digit field;
  - `overflow` ← the final accumulator;
  - done ← 1 and busy ← 0;
  - state returns to IDLE.
- **Overflow result:** when overflow=1, `bcd` holds the true value mod 10^DIGITS (the discarded carries have weight 10^DIGITS).
- **Output holding:** `bcd` and `overflow` hold their values until the next completion; they do not change while busy.
- **start while busy=1:** ignored, and `binary` is not re-sampled. No queueing.
- **start on the edge where done is high:** accepted, because state is already IDLE.
- **Reset:** synchronous and overrides everything, including mid-conversion. It forces:
  - state IDLE, busy=0, done=0;
  - bcd=0, overflow=0;
  - shift register and counter cleared.
  - Any in-flight conversion is discarded and no done is produced for it.
- **Width rules:** digit correction is a 4-bit add with no carry into the neighbouring digit. Correction is evaluated on the register value before the shift of the same iteration.

## Timing
- **Reset values:** busy=0, done=0, bcd=0, overflow=0.
- **Latency:** with the accept edge at E0, iterations occur on E1..E_BIN_W. done=1 and the new bcd are visible in the cycle after E_BIN_W, i.e. BIN_W cycles after accept.
- **Throughput:** one conversion per BIN_W+1 cycles with start held high continuously.
- **done:** exactly one cycle wide; never high while busy=1.
- **busy:** high from the cycle after E0 through the cycle before done, i.e. BIN_W cycles.
- **Degenerate case BIN_W=1:** busy is high for 1 cycle; done follows.

## Test plan
- **Default params, max value and back-to-back:**
  - Stimulus: binary=4095 (0xFFF), start for 1 cycle.
  - Required: busy for 12 cycles, then done with bcd=0x4095 and overflow=0.
  - Then binary=0 with start held: next done 13 cycles later with bcd=0x0000.
- **Default params, mid-range value:**
  - Stimulus: binary=1000.
  - Required: bcd=0x1000, overflow=0.
  - Also: binary=9 gives bcd=0x0009.
- **BIN_W=12, DIGITS=3, overflow:**
  - Stimulus: binary=1234.
  - Required: bcd=0x234, overflow=1.
  - Then binary=999: bcd=0x999, overflow=0.
- **BIN_W=16, DIGITS=5, wide value:**
  - Stimulus: binary=65535.
  - Required: done 16 cycles after accept, bcd=0x65535, overflow=0.
- **Start during busy ignored:**
  - Stimulus: convert 321. On cycle 5 of busy, pulse start with binary=4000.
  - Required: a single done with bcd=0x0321. No second done follows.
- **Reset mid-operation:**
  - Stimulus: start 777, then assert reset on cycle 6 of busy.
  - Required: next cycle busy=0, done=0, bcd=0, overflow=0, and no done is ever produced for 777.
  - Then converting 42 gives bcd=0x0042 with normal latency.

Source files
------------

// File: rtl/bin_bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// Latency : done pulses BIN_W cycles after the accepting edge; one result per BIN_W+1 cycles
// Backpr. : start is ignored while busy (no queueing); bcd/overflow hold until next completion
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, binary    conversion request and value, sampled on the accepting edge only
//   busy             high while a conversion runs
//   done             one-cycle pulse when bcd/overflow are updated
//   bcd              4*DIGITS-bit result, digit 0 (ones) in bcd[3:0]
//   overflow         last result exceeded 10^DIGITS-1 (bcd then holds value mod 10^DIGITS)
module bin_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SR_W  = 4 * DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  // Per-iteration datapath: digit correction, then shift.
  logic [SR_W-1:0]      sr_corr;
  logic [SR_W-1:0]      sr_shift;
  logic                 acc_next;

  always_comb begin
    sr_corr = sr_q;
    // Each digit is corrected independently; the 4-bit add wraps and never
    // carries into the neighbouring digit.
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_q[BIN_W + 4*k +: 4] >= 4'd5) begin
        sr_corr[BIN_W + 4*k +: 4] = sr_q[BIN_W + 4*k +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_corr[SR_W-2:0], 1'b0};
    // The bit leaving the top of the register carries weight 10^DIGITS;
    // any 1 shifted out means the value did not fit.
    acc_next = acc_q | sr_corr[SR_W-1];
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{(4*DIGITS){1'b0}}, binary};
          cnt_d   = '0;
          acc_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_next;
        if (cnt_q == CNT_LAST) begin
          bcd_d   = sr_shift[SR_W-1 -: 4*DIGITS];
          ovf_d   = acc_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: default, 3-digit and 16-bit configurations.
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic reset;

  // Instance A: BIN_W=12, DIGITS=4
  logic        start_a;
  logic [11:0] bin_a;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] bcd_a;

  // Instance B: BIN_W=12, DIGITS=3
  logic        start_b;
  logic [11:0] bin_b;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;

  // Instance C: BIN_W=16, DIGITS=5
  logic        start_c;
  logic [15:0] bin_c;
  logic        busy_c, done_c, ovf_c;
  logic [19:0] bcd_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bin_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin_bcd_seq #(.BIN_W(12), .DIGITS(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .binary(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done_a is seen (bounded). cyc = edges advanced,
  // bsy = cycles observed with busy_a high before done.
  task automatic wait_done_a(input int max, output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (done_a !== 1'b1 && cyc < max) begin
      if (busy_a === 1'b1) bsy++;
      step();
      cyc++;
    end
  endtask

  // Pulse start for one cycle, then wait for completion.
  task automatic run_a(input logic [11:0] val, output int lat, output int bsy);
    bin_a   = val;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done_a(40, lat, bsy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else pass_cnt++;
    total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a); else pass_cnt++;
    total_cnt++; if (bcd_a !== 16'h0000) $display("FAIL reset_bcd: got %h expected 0000", bcd_a); else pass_cnt++;
    total_cnt++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf_a); else pass_cnt++;
    total_cnt++; if (bcd_c !== 20'h00000 || busy_c !== 1'b0) $display("FAIL reset_c: got bcd=%h busy=%b expected 00000/0", bcd_c, busy_c); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_max_back_to_back();
    int lat, bsy, lat2;
    run_a(12'hFFF, lat, bsy);
    total_cnt++; if (lat !== 12) $display("FAIL max_latency: got %0d expected 12", lat); else pass_cnt++;
    total_cnt++; if (bsy !== 12) $display("FAIL max_busy_cycles: got %0d expected 12", bsy); else pass_cnt++;
    total_cnt++; if (bcd_a !== 16'h4095) $display("FAIL max_bcd: got %h expected 4095", bcd_a); else pass_cnt++;
    total_cnt++; if (ovf_a !== 1'b0) $display("FAIL max_ovf: got %b expected 0", ovf_a); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL max_done_with_busy: got busy=%b expected 0", busy_a); else pass_cnt++;
    // start held high from the done cycle: accepted immediately
    bin_a   = 12'd0;
    start_a = 1'b1;
    step();
    total_cnt++; if (done_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL b2b_accept: got done=%b busy=%b expected 0/1", done_a, busy_a); else pass_cnt++;
    wait_done_a(40, lat2, bsy);
    start_a = 1'b0;
    total_cnt++; if (lat2 + 1 !== 13) $display("FAIL b2b_latency: got %0d expected 13", lat2 + 1); else pass_cnt++;
    total_cnt++; if (bcd_a !== 16'h0000) $display("FAIL b2b_bcd: got %h expected 0000", bcd_a); else pass_cnt++;
    step();
    total_cnt++; if (done_a !== 1'b0) $display("FAIL done_width: got %b expected 0", done_a); else pass_cnt++;
    step();
  endtask

  task automatic test_mid_range();
    int lat, bsy;
    run_a(12'd1000, lat, bsy);
    total_cnt++; if (bcd_a !== 16'h1000 || lat !== 12) $display("FAIL mid_1000: got bcd=%h lat=%0d expected 1000/12", bcd_a, lat); else pass_cnt++;
    total_cnt++; if (ovf_a !== 1'b0) $display("FAIL mid_1000_ovf: got %b expected 0", ovf_a); else pass_cnt++;
    step();
    run_a(12'd9, lat, bsy);
    total_cnt++; if (bcd_a !== 16'h0009 || lat !== 12) $display("FAIL mid_9: got bcd=%h lat=%0d expected 0009/12", bcd_a, lat); else pass_cnt++;
    step();
  endtask

  task automatic test_overflow();
    int cyc;
    bin_b   = 12'd1234;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 40) begin step(); cyc++; end
    total_cnt++; if (bcd_b !== 12'h234 || cyc !== 12) $display("FAIL ovf_1234_bcd: got bcd=%h lat=%0d expected 234/12", bcd_b, cyc); else pass_cnt++;
    total_cnt++; if (ovf_b !== 1'b1) $display("FAIL ovf_1234_flag: got %b expected 1", ovf_b); else pass_cnt++;
    step();
    bin_b   = 12'd999;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      // held results must not move while a conversion runs
      if (busy_b === 1'b1 && (bcd_b !== 12'h234 || ovf_b !== 1'b1)) begin
        total_cnt++;
        $display("FAIL ovf_hold: got bcd=%h ovf=%b expected 234/1", bcd_b, ovf_b);
      end
    end
    total_cnt++; if (bcd_b !== 12'h999 || cyc !== 12) $display("FAIL ovf_999_bcd: got bcd=%h lat=%0d expected 999/12", bcd_b, cyc); else pass_cnt++;
    total_cnt++; if (ovf_b !== 1'b0) $display("FAIL ovf_999_flag: got %b expected 0", ovf_b); else pass_cnt++;
    step();
  endtask

  task automatic test_wide();
    int cyc;
    bin_c   = 16'd65535;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    cyc = 0;
    while (done_c !== 1'b1 && cyc < 60) begin step(); cyc++; end
    total_cnt++; if (cyc !== 16) $display("FAIL wide_latency: got %0d expected 16", cyc); else pass_cnt++;
    total_cnt++; if (bcd_c !== 20'h65535 || ovf_c !== 1'b0) $display("FAIL wide_bcd: got bcd=%h ovf=%b expected 65535/0", bcd_c, ovf_c); else pass_cnt++;
    step();
  endtask

  task automatic test_start_busy();
    int lat, bsy, dones;
    bin_a   = 12'd321;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step(); step();  // now in busy cycle 5
    bin_a   = 12'd4000;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    bin_a   = 12'd0;
    wait_done_a(40, lat, bsy);
    total_cnt++; if (lat + 5 !== 12) $display("FAIL busy_start_latency: got %0d expected 12", lat + 5); else pass_cnt++;
    total_cnt++; if (bcd_a !== 16'h0321) $display("FAIL busy_start_bcd: got %h expected 0321", bcd_a); else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done_a === 1'b1) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL busy_start_extra_done: got %0d expected 0", dones); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bsy, dones;
    bin_a   = 12'd777;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step(); step(); step();  // now in busy cycle 6
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_mid_ctrl: got busy=%b done=%b expected 0/0", busy_a, done_a); else pass_cnt++;
    total_cnt++; if (bcd_a !== 16'h0000 || ovf_a !== 1'b0) $display("FAIL rst_mid_data: got bcd=%h ovf=%b expected 0000/0", bcd_a, ovf_a); else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done_a === 1'b1) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL rst_mid_stray_done: got %0d expected 0", dones); else pass_cnt++;
    run_a(12'd42, lat, bsy);
    total_cnt++; if (bcd_a !== 16'h0042 || lat !== 12) $display("FAIL rst_mid_42: got bcd=%h lat=%0d expected 0042/12", bcd_a, lat); else pass_cnt++;
    step();
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; bin_a = '0;
    start_b = 1'b0; bin_b = '0;
    start_c = 1'b0; bin_c = '0;
    test_reset();
    test_max_back_to_back();
    test_mid_range();
    test_overflow();
    test_wide();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
